// File: rtl/ahb_led_ctrl.sv
// ahb_led_ctrl: AHB-Lite zero-wait slave driving NUM_LEDS LED channels.
// Each channel runs in one of four modes: off, on, blink or PWM. One shared
// prescaler sets the pace for every channel.
// Optional feature macro: LED_PWM_EN. When it is defined, the block has a PWM
// counter and per-channel duty storage. When it is undefined, mode 3 drives
// the LED on and the duty bits read as 0.
//
// Bus handshake: an address phase is accepted on an edge where
// HSEL & HREADY & HTRANS[1]. Its data phase completes on the next edge that
// has HREADY high, and the write or read takes place in that data phase. This
// slave never stalls (HREADYOUT = 1) and never signals an error (HRESP = 0).
module ahb_led_ctrl #(
  parameter int NUM_LEDS = 3,
  parameter int PWM_W    = 8,
  parameter int PRESC_W  = 16
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                HSEL,
  input  logic [7:0]          HADDR,
  input  logic [1:0]          HTRANS,
  input  logic                HWRITE,
  input  logic                HREADY,
  input  logic [31:0]         HWDATA,
  output logic [31:0]         HRDATA,
  output logic                HREADYOUT,
  output logic                HRESP,
  output logic [NUM_LEDS-1:0] LED_out
);

  // Bus state for the data phase that is in progress.
  logic       dp_valid;
  logic       dp_write;
  logic [5:0] dp_word;

  // Programmable registers.
  logic               en;
  logic [PRESC_W-1:0] presc;
  logic [1:0]         mode [NUM_LEDS];
  logic [15:0]        half [NUM_LEDS];
`ifdef LED_PWM_EN
  logic [PWM_W-1:0]   duty [NUM_LEDS];
  logic [PWM_W-1:0]   pwm_cnt;
`endif

  // Counters.
  logic [PRESC_W-1:0] presc_cnt;
  logic [15:0]        blink_cnt [NUM_LEDS];
  logic               phase [NUM_LEDS];

  logic                wr_en;
  logic                wr_ctrl;
  logic                wr_presc;
  logic [NUM_LEDS-1:0] wr_ch;
  logic                presc_force;
  logic                tick;
  logic [NUM_LEDS-1:0] led_nxt;
  logic                unused_bus;

  assign HREADYOUT  = 1'b1;
  assign HRESP      = 1'b0;
  assign unused_bus = ^{HADDR[1:0], HTRANS[0], HWDATA};

  // Latch the accepted address phase so the next cycle can perform the access.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_word  <= 6'd0;
    end else if (HREADY) begin
      dp_valid <= HSEL & HTRANS[1];
      dp_write <= HWRITE;
      dp_word  <= HADDR[7:2];
    end
  end

  // Decode the write strobes for the data phase that completes on this edge.
  always_comb begin
    wr_en    = dp_valid & dp_write & HREADY;
    wr_ctrl  = wr_en && (dp_word == 6'd0);
    wr_presc = wr_en && (dp_word == 6'd1);
    wr_ch    = '0;
    for (int i = 0; i < NUM_LEDS; i++)
      wr_ch[i] = wr_en && (dp_word == 6'(i + 4));
  end

  // Form the tick. Lowering PRESCALE below the running count restarts the
  // count and produces no tick on that edge.
  always_comb begin
    presc_force = wr_presc && (HWDATA[PRESC_W-1:0] < presc_cnt);
    tick        = en && (presc_cnt == presc) && !presc_force;
  end

  // Register file writes.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      en    <= 1'b0;
      presc <= '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        mode[i] <= 2'd0;
        half[i] <= 16'd0;
`ifdef LED_PWM_EN
        duty[i] <= '0;
`endif
      end
    end else begin
      if (wr_ctrl)  en    <= HWDATA[0];
      if (wr_presc) presc <= HWDATA[PRESC_W-1:0];
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (wr_ch[i]) begin
          mode[i] <= HWDATA[1:0];
          half[i] <= HWDATA[31:16];
`ifdef LED_PWM_EN
          duty[i] <= HWDATA[8 +: PWM_W];
`endif
        end
      end
    end
  end

  // The prescaler and PWM counter advance while the block is enabled and are
  // held at 0 while it is disabled.
  always_ff @(posedge HCLK) begin
    if (!HRESETn || !en) begin
      presc_cnt <= '0;
`ifdef LED_PWM_EN
      pwm_cnt   <= '0;
`endif
    end else begin
      if (presc_force || (presc_cnt == presc))
        presc_cnt <= '0;
      else
        presc_cnt <= presc_cnt + PRESC_W'(1);
`ifdef LED_PWM_EN
      if (tick) pwm_cnt <= pwm_cnt + PWM_W'(1);
`endif
    end
  end

  // Per-channel blink counters. A write to a channel restarts its blink
  // sequence in the off phase.
  always_ff @(posedge HCLK) begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (!HRESETn || !en || wr_ch[i]) begin
        blink_cnt[i] <= 16'd0;
        phase[i]     <= 1'b0;
      end else if (tick) begin
        if (blink_cnt[i] == half[i]) begin
          blink_cnt[i] <= 16'd0;
          phase[i]     <= ~phase[i];
        end else begin
          blink_cnt[i] <= blink_cnt[i] + 16'd1;
        end
      end
    end
  end

  // Select each channel's LED level from its mode.
  always_comb begin
    led_nxt = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      case (mode[i])
        2'd0:    led_nxt[i] = 1'b0;
        2'd1:    led_nxt[i] = 1'b1;
        2'd2:    led_nxt[i] = phase[i];
`ifdef LED_PWM_EN
        default: led_nxt[i] = (pwm_cnt < duty[i]);
`else
        default: led_nxt[i] = 1'b1;
`endif
      endcase
    end
  end

  // Registered LED drive. Every LED is dark while the block is disabled.
  always_ff @(posedge HCLK) begin
    if (!HRESETn || !en)
      LED_out <= '0;
    else
      LED_out <= led_nxt;
  end

  // Read mux. HRDATA is 0 outside a read data phase and for unmapped words.
  always_comb begin
    HRDATA = 32'd0;
    if (dp_valid && !dp_write) begin
      if (dp_word == 6'd0)
        HRDATA = {31'd0, en};
      else if (dp_word == 6'd1)
        HRDATA = 32'(presc);
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (dp_word == 6'(i + 4)) begin
          HRDATA = {half[i], 14'd0, mode[i]};
`ifdef LED_PWM_EN
          HRDATA[8 +: PWM_W] = duty[i];
`endif
        end
      end
    end
  end

endmodule
